aes_encipher_iter: RTL
======================

// Module: aes_encipher_iter
// PURPOSE
//  Iterative AES block encipher datapath: holds the 128-bit state and runs initial, Nr-1 main and final
//  rounds for AES-128 (Nr=10) or AES-256 (Nr=14). SubBytes goes through SBOX_LANES shared external S-box
//  lanes, so area/latency is set by one parameter. Sits between key memory (round_key/round) and core control.
// PARAMETERS
//  SBOX_LANES  4  parallel S-box lookups per cycle; legal values 1,2,4,8,16 (must divide 16)
// PORTS
//  clk        in   1            clock, all state updates on rising edge
//  reset_n    in   1            synchronous reset, active low
//  next       in   1            start request; accepted only while ready=1
//  keylen     in   1            0=AES-128, 1=AES-256; sampled at accept
//  block      in   128          plaintext; byte k at [127-8k -: 8], column-major per FIPS-197; sampled at accept
//  round      out  4            index of round key wanted this cycle (0..Nr)
//  round_key  in   128          key for 'round', combinational from key memory, same cycle
//  sbox_addr  out  8*SBOX_LANES lane i at [8i+7:8i]
//  sbox_data  in   8*SBOX_LANES combinational S-box result per lane, same cycle
//  new_block  out  128          ciphertext; valid while ready=1 after a completed run
//  ready      out  1            1 = idle, can accept next
//  valid      out  1            one-cycle pulse when new_block is updated
// BEHAVIOUR
//  Reset: state, new_block=0, round=0, sbox_addr=0, ready=1, valid=0, FSM=IDLE.
//  One clock, synchronous active-low reset; reset mid-run aborts immediately to IDLE, no valid pulse.
//  FSM: IDLE -> INIT -> SUB -> (MIX | FINAL) -> SUB ... -> DONE -> IDLE.
//   IDLE : ready=1. next=1 -> latch block/keylen, ready=0, round=0, go INIT. next while busy is ignored.
//   INIT : state <= block ^ round_key(0); round<=1; step<=0; go SUB.
//   SUB  : step j=0..16/SBOX_LANES-1; lane i addresses state byte j*SBOX_LANES+i, result written back
//          same edge. Last step -> MIX if round<Nr, else FINAL.
//   MIX  : state <= AddRoundKey(MixColumns(ShiftRows(state)), round_key); round<=round+1; go SUB.
//   FINAL: new_block <= ShiftRows(state) ^ round_key(Nr); valid=1 next cycle; go DONE.
//   DONE : ready<=1, round<=0; go IDLE (1 cycle).
//  ShiftRows: row r rotated left by r. MixColumns per FIPS-197 [2 3 1 1] circulant, GF(2^8) poly 0x11b;
//   every output byte uses only pre-mix bytes of its own column.
//  Latency accept->valid = 2 + Nr*(16/SBOX_LANES + 1) cycles (AES-128, 4 lanes: 52).
//  sbox_addr is 0 outside SUB. new_block holds last result until next valid; not cleared on accept.
//  round wraps nowhere: max 14, 4 bits suffice; keylen change while busy has no effect.
// STRUCTURE
//  Shared package/include aes_params: AES128_ROUNDS=10, AES256_ROUNDS=14, FSM state encodings,
//   gm2/gm3 GF functions (also used by the decipher side).
//  Sub-module aes_mixcolumn: combinational 32-bit single-column mix, instantiated 4x.
//  Lane mux and step counter stay in this module; S-boxes are external and shared with key expansion.
// TESTING
//  FIPS-197 C.1: key 000102..0f, block 00112233445566778899aabbccddeeff, keylen=0, 4 lanes
//   -> new_block 69c4e0d86a7b0430d8cdb78070b4c55a, valid 52 cycles after accept.
//  FIPS-197 C.3: key 000102..1f, same block, keylen=1 -> 8ea2b7ca516745bfeafc49904b496089, latency 72.
//  Lane sweep SBOX_LANES=1/16 on C.1 -> same ciphertext, latency 172 / 22; sbox_addr lanes match bytes.
//  next pulsed every cycle during a run with different block -> ignored, result still C.1 vector.
//  reset_n low at cycle 20 of a run -> next cycle ready=1, valid=0, new_block=0; fresh run then correct.
//  Back-to-back: next held high -> second run accepted the cycle ready=1; both vectors correct.

Source files
------------

// File: rtl/aes_encipher_iter_pkg.sv
// aes_encipher_iter_pkg: round counts, FSM encoding and GF(2^8) helpers shared by the AES datapaths
package aes_encipher_iter_pkg;
   localparam int AES128_ROUNDS = 10;
   localparam int AES256_ROUNDS = 14;
   typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_SUB, ST_MIX, ST_FINAL, ST_DONE} state_e;
   function automatic logic [7:0] gm2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gm3(input logic [7:0] b);
      return gm2(b) ^ b;
   endfunction
   // byte k = 4*col + row sits at [127-8k -: 8]; row r rotates left by r columns
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] t;
      t = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return t;
   endfunction
endpackage

// File: rtl/aes_encipher_iter_mixcolumn.sv
// aes_encipher_iter_mixcolumn: single-column MixColumns, row 0 in the top byte
module aes_encipher_iter_mixcolumn
   import aes_encipher_iter_pkg::*;
(
   input  logic [31:0] col_i,
   output logic [31:0] col_o
);
   logic [7:0] a0, a1, a2, a3;
   assign {a0, a1, a2, a3} = col_i;
   assign col_o = {gm2(a0) ^ gm3(a1) ^ a2 ^ a3,
                   a0 ^ gm2(a1) ^ gm3(a2) ^ a3,
                   a0 ^ a1 ^ gm2(a2) ^ gm3(a3),
                   gm3(a0) ^ a1 ^ a2 ^ gm2(a3)};
endmodule

// File: rtl/aes_encipher_iter.sv
// aes_encipher_iter: iterative AES-128/256 encipher round datapath with SBOX_LANES shared external S-boxes
module aes_encipher_iter
   import aes_encipher_iter_pkg::*;
#(
   parameter int SBOX_LANES = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    next_i,
   input  logic                    keylen_i,
   input  logic [127:0]            block_i,
   output logic [3:0]              round_o,
   input  logic [127:0]            round_key_i,
   output logic [8*SBOX_LANES-1:0] sbox_addr_o,
   input  logic [8*SBOX_LANES-1:0] sbox_data_i,
   output logic [127:0]            new_block_o,
   output logic                    ready_o,
   output logic                    valid_o
);
   localparam int STEPS = 16 / SBOX_LANES;
   localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);
   state_e fsm_q, fsm_d;
   logic [127:0] state_q, state_d, new_block_q, new_block_d, sr, mixed, sub_state;
   logic [3:0] round_q, round_d, step_q, step_d, nr;
   logic keylen_q, keylen_d, ready_q, ready_d, valid_q, valid_d;
   assign nr = keylen_q ? 4'(AES256_ROUNDS) : 4'(AES128_ROUNDS);
   assign sr = shift_rows(state_q);
   for (genvar c = 0; c < 4; c++) begin : g_mix
      aes_encipher_iter_mixcolumn u_mix (.col_i(sr[127-32*c -: 32]), .col_o(mixed[127-32*c -: 32]));
   end
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         fsm_q       <= ST_IDLE;
         state_q     <= '0;
         new_block_q <= '0;
         round_q     <= '0;
         step_q      <= '0;
         keylen_q    <= 1'b0;
         ready_q     <= 1'b1;
         valid_q     <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         new_block_q <= new_block_d;
         round_q     <= round_d;
         step_q      <= step_d;
         keylen_q    <= keylen_d;
         ready_q     <= ready_d;
         valid_q     <= valid_d;
      end
   end
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         ST_IDLE:  fsm_d = next_i ? ST_INIT : ST_IDLE;
         ST_INIT:  fsm_d = ST_SUB;
         ST_SUB:   fsm_d = (step_q != LAST_STEP) ? ST_SUB : (round_q < nr) ? ST_MIX : ST_FINAL;
         ST_MIX:   fsm_d = ST_SUB;
         ST_FINAL: fsm_d = ST_DONE;
         default:  fsm_d = ST_IDLE;
      endcase
   end
   // lane i of step j handles state byte j*SBOX_LANES+i; idle lanes present address 0
   always_comb begin
      sub_state   = state_q;
      sbox_addr_o = '0;
      for (int k = 0; k < 16; k++)
         if (fsm_q == ST_SUB && 4'(k / SBOX_LANES) == step_q) begin
            sbox_addr_o[8*(k%SBOX_LANES) +: 8] = state_q[127-8*k -: 8];
            sub_state[127-8*k -: 8]            = sbox_data_i[8*(k%SBOX_LANES) +: 8];
         end
   end
   always_comb begin
      state_d     = state_q;
      new_block_d = new_block_q;
      round_d     = round_q;
      step_d      = step_q;
      keylen_d    = keylen_q;
      ready_d     = ready_q;
      valid_d     = 1'b0;
      case (fsm_q)
         ST_IDLE: if (next_i) begin
            state_d  = block_i;
            keylen_d = keylen_i;
            ready_d  = 1'b0;
            round_d  = '0;
         end
         ST_INIT: begin
            state_d = state_q ^ round_key_i;
            round_d = 4'd1;
            step_d  = '0;
         end
         ST_SUB: begin
            state_d = sub_state;
            step_d  = (step_q == LAST_STEP) ? 4'd0 : step_q + 4'd1;
         end
         ST_MIX: begin
            state_d = mixed ^ round_key_i;
            round_d = round_q + 4'd1;
         end
         ST_FINAL: begin
            new_block_d = sr ^ round_key_i;
            valid_d     = 1'b1;
         end
         default: begin
            ready_d = 1'b1;
            round_d = '0;
         end
      endcase
   end
   assign round_o     = round_q;
   assign new_block_o = new_block_q;
   assign ready_o     = ready_q;
   assign valid_o     = valid_q;
endmodule
